mmio_timer: RTL and testbench

//  Memory-mapped countdown timer; the responder for the CPU's M-stage load/store port (the bridge forwards in-window accesses).

---
 rtl/mmio_timer_pkg.sv | 34 +++
 rtl/mmio_timer.sv | 133 +++++++++++++
 tb/tb_mmio_timer.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mmio_timer_pkg.sv
// Shared definitions for the memory-mapped countdown timer: register offsets,
// CTRL field layout, mode and FSM state encodings, and the bridge address window.
package mmio_timer_pkg;

  localparam logic [31:0] TIMER_ADDR_BEGIN = 32'h0000_7F10;
  localparam logic [31:0] TIMER_ADDR_END   = 32'h0000_7F1F;

  localparam logic [1:0] TIMER_REG_CTRL   = 2'd0;
  localparam logic [1:0] TIMER_REG_PRESET = 2'd1;
  localparam logic [1:0] TIMER_REG_COUNT  = 2'd2;

  localparam int TIMER_CTRL_EN_BIT   = 0;
  localparam int TIMER_CTRL_MODE_LSB = 1;
  localparam int TIMER_CTRL_IM_BIT   = 3;
  localparam int TIMER_CTRL_W        = 4;

  localparam logic [1:0] TIMER_MODE_ONESHOT = 2'b00;
  localparam logic [1:0] TIMER_MODE_RELOAD  = 2'b01;

  typedef enum logic [1:0] {
    TIMER_STATE_IDLE = 2'd0,
    TIMER_STATE_LOAD = 2'd1,
    TIMER_STATE_CNT  = 2'd2,
    TIMER_STATE_INT  = 2'd3
  } timer_state_e;

  // Packed so that the struct lines up bit-for-bit with CTRL[3:0].
  typedef struct packed {
    logic       im;
    logic [1:0] mode;
    logic       en;
  } timer_ctrl_t;

endpackage

// File: rtl/mmio_timer.sv
// Memory-mapped countdown timer with CTRL/PRESET/COUNT registers, a small
// load/count/expire FSM and a maskable interrupt; reads are combinational.
module mmio_timer
  import mmio_timer_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic [3:0]  addr,
  input  logic        write_en,
  input  logic [3:0]  byte_en,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        irq
);

  timer_ctrl_t        ctrl_q;
  timer_ctrl_t        ctrl_d;
  logic [CNT_W-1:0]   preset_q;
  logic [CNT_W-1:0]   preset_d;
  logic [CNT_W-1:0]   count_q;
  timer_state_e       state_q;
  logic               pending_q;

  logic               wr_hit;
  logic               wr_ctrl;
  logic               wr_preset;
  logic [31:0]        preset_ext;
  logic [31:0]        ctrl_merged;
  logic [31:0]        preset_merged;
  logic               unused_bits;

  function automatic logic [31:0] merge_lanes(input logic [31:0] cur,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = cur;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) begin
        res[8*i +: 8] = wdata[8*i +: 8];
      end
    end
    return res;
  endfunction

  assign wr_hit    = sel & write_en;
  assign wr_ctrl   = wr_hit & (addr[3:2] == TIMER_REG_CTRL);
  assign wr_preset = wr_hit & (addr[3:2] == TIMER_REG_PRESET);

  always_comb begin
    preset_ext                = '0;
    preset_ext[CNT_W-1:0]     = preset_q;
    ctrl_merged               = merge_lanes({{(32-TIMER_CTRL_W){1'b0}}, ctrl_q},
                                            write_data, byte_en);
    preset_merged             = merge_lanes(preset_ext, write_data, byte_en);
    ctrl_d                    = timer_ctrl_t'(ctrl_merged[TIMER_CTRL_W-1:0]);
    preset_d                  = preset_merged[CNT_W-1:0];
  end

  assign unused_bits = ^{addr[1:0], ctrl_merged[31:TIMER_CTRL_W], preset_merged};

  // Register writes are applied after the FSM so a CPU store to CTRL overrides
  // the FSM's EN clear, and any CTRL/PRESET store overrides a pending set.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q    <= '0;
      preset_q  <= '0;
      count_q   <= '0;
      state_q   <= TIMER_STATE_IDLE;
      pending_q <= 1'b0;
    end else begin
      case (state_q)
        TIMER_STATE_IDLE: begin
          if (ctrl_q.en) begin
            state_q <= TIMER_STATE_LOAD;
          end
        end
        TIMER_STATE_LOAD: begin
          count_q <= preset_q;
          state_q <= TIMER_STATE_CNT;
        end
        TIMER_STATE_CNT: begin
          if (!ctrl_q.en) begin
            state_q <= TIMER_STATE_IDLE;
          end else if (count_q > CNT_W'(1)) begin
            count_q <= count_q - CNT_W'(1);
          end else begin
            // Covers COUNT==1 and PRESET==0 alike: expire without wrapping.
            count_q   <= '0;
            pending_q <= 1'b1;
            state_q   <= TIMER_STATE_INT;
          end
        end
        TIMER_STATE_INT: begin
          state_q <= TIMER_STATE_IDLE;
          if (ctrl_q.mode == TIMER_MODE_RELOAD) begin
            pending_q <= 1'b0;
          end else begin
            ctrl_q.en <= 1'b0;
          end
        end
        default: state_q <= TIMER_STATE_IDLE;
      endcase

      if (wr_ctrl) begin
        ctrl_q <= ctrl_d;
      end
      if (wr_preset) begin
        preset_q <= preset_d;
      end
      if (wr_ctrl || wr_preset) begin
        pending_q <= 1'b0;
      end
    end
  end

  always_comb begin
    read_data = '0;
    if (sel) begin
      case (addr[3:2])
        TIMER_REG_CTRL:   read_data[TIMER_CTRL_W-1:0] = ctrl_q;
        TIMER_REG_PRESET: read_data[CNT_W-1:0]        = preset_q;
        TIMER_REG_COUNT:  read_data[CNT_W-1:0]        = count_q;
        default:          read_data                   = '0;
      endcase
    end
  end

  assign irq = ctrl_q.im & pending_q;

endmodule

// File: tb/tb_mmio_timer.sv
// Self-checking bench for mmio_timer: directed scenarios with spec-derived
// constants plus a randomized run against a behavioural register/timer model.
module tb_mmio_timer;

  logic        clk = 1'b0;
  logic        reset;
  logic        sel;
  logic [3:0]  addr;
  logic        write_en;
  logic [3:0]  byte_en;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        irq;

  int n_tests = 0;
  int n_fail  = 0;

  mmio_timer #(.CNT_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .sel        (sel),
    .addr       (addr),
    .write_en   (write_en),
    .byte_en    (byte_en),
    .write_data (write_data),
    .read_data  (read_data),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  // Behavioural model: timer phases follow the register-level rules directly.
  localparam int PH_IDLE = 0, PH_LOAD = 1, PH_RUN = 2, PH_EXPIRED = 3;
  bit        m_en, m_im, m_pending;
  bit [1:0]  m_mode;
  bit [31:0] m_preset, m_count;
  int        m_phase;

  task automatic model_edge();
    bit hit, wc, wp;
    bit [3:0] old_ctrl;
    if (reset) begin
      m_en = 0; m_mode = 0; m_im = 0; m_preset = 0; m_count = 0;
      m_pending = 0; m_phase = PH_IDLE;
      return;
    end
    hit = sel && write_en;
    wc = hit && (addr[3:2] == 2'd0);
    wp = hit && (addr[3:2] == 2'd1);
    old_ctrl = {m_im, m_mode, m_en};
    case (m_phase)
      PH_IDLE: if (m_en) m_phase = PH_LOAD;
      PH_LOAD: begin m_count = m_preset; m_phase = PH_RUN; end
      PH_RUN: begin
        if (!m_en) m_phase = PH_IDLE;
        else if (m_count > 1) m_count = m_count - 1;
        else begin m_count = 0; m_pending = 1; m_phase = PH_EXPIRED; end
      end
      default: begin
        m_phase = PH_IDLE;
        if (m_mode == 2'b01) m_pending = 0;
        else m_en = 0;
      end
    endcase
    if (wc) begin
      if (byte_en[0]) {m_im, m_mode, m_en} = write_data[3:0];
      else {m_im, m_mode, m_en} = old_ctrl;
    end
    if (wp) begin
      for (int i = 0; i < 4; i++)
        if (byte_en[i]) m_preset[8*i +: 8] = write_data[8*i +: 8];
    end
    if (wc || wp) m_pending = 0;
  endtask

  function automatic logic [31:0] exp_read(input logic [3:0] a);
    case (a[3:2])
      2'd0:    return {28'd0, m_im, m_mode, m_en};
      2'd1:    return m_preset;
      2'd2:    return m_count;
      default: return 32'd0;
    endcase
  endfunction

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    sel = 1; write_en = 1; addr = a; write_data = d; byte_en = be;
    cycle();
    write_en = 0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] d);
    sel = 1; write_en = 0; addr = a;
    #1;
    d = read_data;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    reset = 1; sel = 0; write_en = 0; addr = 0; byte_en = 0; write_data = 0;
    idle(3);
    reset = 0;
    rd(4'h0, v); n_tests++;
    if (v !== 32'h0) begin n_fail++; $display("FAIL reset_ctrl: got %0h expected 0", v); end
    rd(4'h4, v); n_tests++;
    if (v !== 32'h0) begin n_fail++; $display("FAIL reset_preset: got %0h expected 0", v); end
    rd(4'h8, v); n_tests++;
    if (v !== 32'h0) begin n_fail++; $display("FAIL reset_count: got %0h expected 0", v); end
    n_tests++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b expected 0", irq); end
    wr(4'h8, 32'h55, 4'hF);
    rd(4'h8, v); n_tests++;
    if (v !== 32'h0) begin n_fail++; $display("FAIL count_readonly: got %0h expected 0", v); end
    sel = 0; write_en = 1; addr = 4'h4; write_data = 32'h1234; byte_en = 4'hF;
    cycle();
    write_en = 0;
    #1; n_tests++;
    if (read_data !== 32'h0) begin n_fail++; $display("FAIL sel0_read: got %0h expected 0", read_data); end
    rd(4'h4, v); n_tests++;
    if (v !== 32'h0) begin n_fail++; $display("FAIL sel0_write: got %0h expected 0", v); end
  endtask

  task automatic test_oneshot();
    logic [31:0] v;
    int first = -1;
    wr(4'h4, 32'd3, 4'hF);
    wr(4'h0, 32'h9, 4'hF);
    for (int k = 1; k <= 12; k++) begin
      cycle();
      if (irq === 1'b1 && first < 0) first = k;
      rd(4'h8, v);
      if (k >= 2 && k <= 5) begin
        n_tests++;
        if (v !== 32'(5 - k)) begin n_fail++; $display("FAIL oneshot_count k=%0d: got %0h expected %0h", k, v, 5 - k); end
      end
    end
    n_tests++;
    if (first !== 5) begin n_fail++; $display("FAIL oneshot_latency: got %0d expected 5", first); end
    rd(4'h0, v); n_tests++;
    if (v !== 32'h8) begin n_fail++; $display("FAIL oneshot_en_clear: got %0h expected 8", v); end
    n_tests++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL oneshot_irq_hold: got %b expected 1", irq); end
    wr(4'h0, 32'h8, 4'hF);
    n_tests++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL oneshot_irq_clear: got %b expected 0", irq); end
  endtask

  task automatic test_autoreload();
    int highs[$];
    wr(4'h4, 32'd2, 4'hF);
    wr(4'h0, 32'hB, 4'hF);
    for (int k = 1; k <= 20; k++) begin
      cycle();
      if (irq === 1'b1) highs.push_back(k);
    end
    n_tests++;
    if (highs.size() != 4) begin n_fail++; $display("FAIL reload_pulses: got %0d expected 4", highs.size()); end
    for (int i = 0; i < highs.size() && i < 4; i++) begin
      n_tests++;
      if (highs[i] !== 4 + 5 * i) begin n_fail++; $display("FAIL reload_pulse%0d: got %0d expected %0d", i, highs[i], 4 + 5 * i); end
    end
    wr(4'h0, 32'h0, 4'hF);
    idle(4);
    n_tests++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL reload_stop_irq: got %b expected 0", irq); end
  endtask

  task automatic test_pause_mask();
    logic [31:0] v;
    bit found = 0;
    wr(4'h4, 32'd10, 4'hF);
    wr(4'h0, 32'h1, 4'hF);
    for (int k = 0; k < 30 && !found; k++) begin
      rd(4'h8, v);
      if (v === 32'd7) found = 1;
      else cycle();
    end
    n_tests++;
    if (!found) begin n_fail++; $display("FAIL pause_reach7: got %0h expected 7", v); end
    wr(4'h0, 32'h0, 4'hF);
    for (int j = 0; j < 5; j++) begin
      rd(4'h8, v); n_tests++;
      if (v !== 32'd6) begin n_fail++; $display("FAIL pause_hold j=%0d: got %0h expected 6", j, v); end
      cycle();
    end
    wr(4'h0, 32'h1, 4'hF);
    for (int k = 0; k < 16; k++) begin
      cycle(); n_tests++;
      if (irq !== 1'b0) begin n_fail++; $display("FAIL mask_irq k=%0d: got %b expected 0", k, irq); end
    end
    rd(4'h0, v); n_tests++;
    if (v !== 32'h0) begin n_fail++; $display("FAIL mask_en_clear: got %0h expected 0", v); end
    wr(4'h0, 32'h8, 4'hF);
    cycle(); n_tests++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL mask_write_clears: got %b expected 0", irq); end
  endtask

  task automatic test_bytes_collision();
    logic [31:0] v;
    wr(4'h4, 32'h0, 4'hF);
    wr(4'h4, 32'hAABBCCDD, 4'b0010);
    rd(4'h4, v); n_tests++;
    if (v !== 32'h0000CC00) begin n_fail++; $display("FAIL lane1: got %0h expected 0000cc00", v); end
    wr(4'h4, 32'h11223344, 4'b1001);
    rd(4'h4, v); n_tests++;
    if (v !== 32'h1100CC44) begin n_fail++; $display("FAIL lane03: got %0h expected 1100cc44", v); end
    // CTRL store on the edge the one-shot expiry would clear EN.
    wr(4'h4, 32'd1, 4'hF);
    wr(4'h0, 32'h9, 4'hF);
    idle(3);
    n_tests++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL preset1_latency: got %b expected 1", irq); end
    wr(4'h0, 32'hB, 4'hF);
    rd(4'h0, v); n_tests++;
    if (v !== 32'hB) begin n_fail++; $display("FAIL ctrl_collision: got %0h expected b", v); end
    n_tests++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL ctrl_collision_irq: got %b expected 0", irq); end
    wr(4'h0, 32'h0, 4'hF);
    idle(4);
    // PRESET store on the edge that would set the pending flag.
    wr(4'h4, 32'd1, 4'hF);
    wr(4'h0, 32'h9, 4'hF);
    idle(2);
    wr(4'h4, 32'd1, 4'hF);
    n_tests++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL write_beats_set: got %b expected 0", irq); end
    cycle();
    rd(4'h0, v); n_tests++;
    if (v !== 32'h8) begin n_fail++; $display("FAIL write_beats_set_ctrl: got %0h expected 8", v); end
    n_tests++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL write_beats_set_irq: got %b expected 0", irq); end
  endtask

  task automatic test_reset_midcount();
    logic [31:0] v;
    bit found = 0;
    int first = -1;
    wr(4'h4, 32'd20, 4'hF);
    wr(4'h0, 32'h9, 4'hF);
    for (int k = 0; k < 40 && !found; k++) begin
      rd(4'h8, v);
      if (v === 32'd7) found = 1;
      else cycle();
    end
    n_tests++;
    if (!found) begin n_fail++; $display("FAIL midreset_reach7: got %0h expected 7", v); end
    reset = 1;
    cycle();
    reset = 0;
    rd(4'h0, v); n_tests++;
    if (v !== 32'h0) begin n_fail++; $display("FAIL midreset_ctrl: got %0h expected 0", v); end
    rd(4'h4, v); n_tests++;
    if (v !== 32'h0) begin n_fail++; $display("FAIL midreset_preset: got %0h expected 0", v); end
    rd(4'h8, v); n_tests++;
    if (v !== 32'h0) begin n_fail++; $display("FAIL midreset_count: got %0h expected 0", v); end
    n_tests++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL midreset_irq: got %b expected 0", irq); end
    wr(4'h4, 32'd0, 4'hF);
    wr(4'h0, 32'h9, 4'hF);
    for (int k = 1; k <= 8; k++) begin
      cycle();
      if (irq === 1'b1 && first < 0) first = k;
    end
    n_tests++;
    if (first !== 3) begin n_fail++; $display("FAIL preset0_latency: got %0d expected 3", first); end
  endtask

  task automatic test_random();
    logic [3:0]  ra;
    logic [31:0] exp_v;
    for (int n = 0; n < 400; n++) begin
      reset      = ($urandom_range(0, 99) == 0);
      sel        = ($urandom_range(0, 3) != 0);
      write_en   = ($urandom_range(0, 3) == 0);
      addr       = 4'($urandom);
      byte_en    = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom);
      write_data = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 12));
      cycle();
      reset = 0; write_en = 0;
      n_tests++;
      if (irq !== (m_im & m_pending)) begin n_fail++; $display("FAIL rand_irq n=%0d: got %b expected %b", n, irq, m_im & m_pending); end
      ra = 4'($urandom);
      sel = 1; addr = ra;
      #1;
      exp_v = exp_read(ra);
      n_tests++;
      if (read_data !== exp_v) begin n_fail++; $display("FAIL rand_read n=%0d addr=%0h: got %0h expected %0h", n, ra, read_data, exp_v); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_oneshot();
    test_autoreload();
    test_pause_mask();
    test_bytes_collision();
    test_reset_midcount();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
